// File: rtl/music_pkg.sv
// Shared definitions for the music tone sequencer.
// - Note codes: 0 rest, 1..12 = C4..B4 chromatic, 13..15 rest.
// - HALF_PERIOD: tone half-period in 25.175 MHz pixel clocks for codes 1..12.
// - SONG: fixed 16-step melody ROM (only the first SONG_LEN steps are played).
// - state_e: sequencer FSM states.
package music_pkg;

   localparam logic [3:0] NOTE_REST = 4'd0;
   localparam logic [3:0] NOTE_C4   = 4'd1;
   localparam logic [3:0] NOTE_CS4  = 4'd2;
   localparam logic [3:0] NOTE_D4   = 4'd3;
   localparam logic [3:0] NOTE_DS4  = 4'd4;
   localparam logic [3:0] NOTE_E4   = 4'd5;
   localparam logic [3:0] NOTE_F4   = 4'd6;
   localparam logic [3:0] NOTE_FS4  = 4'd7;
   localparam logic [3:0] NOTE_G4   = 4'd8;
   localparam logic [3:0] NOTE_GS4  = 4'd9;
   localparam logic [3:0] NOTE_A4   = 4'd10;
   localparam logic [3:0] NOTE_AS4  = 4'd11;
   localparam logic [3:0] NOTE_B4   = 4'd12;
   localparam logic [3:0] NOTE_R14  = 4'd14;

   // round(25_175_000 / (2 * f)), f taken to 0.01 Hz; index 0 is C4.
   localparam logic [15:0] HALF_PERIOD [12] = '{
      16'd48112, 16'd45413, 16'd42864, 16'd40457, 16'd38187, 16'd36044,
      16'd34021, 16'd32111, 16'd30309, 16'd28608, 16'd27003, 16'd25487
   };

   localparam logic [3:0] SONG [16] = '{
      NOTE_A4, NOTE_R14, NOTE_E4, NOTE_REST, NOTE_C4, NOTE_B4, NOTE_G4, NOTE_D4,
      4'd13,   NOTE_A4,  NOTE_FS4, NOTE_REST, NOTE_F4, 4'd15,  NOTE_CS4, NOTE_GS4
   };

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;

   function automatic logic is_pitched(logic [3:0] code);
      return (code >= NOTE_C4) && (code <= NOTE_B4);
   endfunction

   // Rest codes still get a valid period so the free-running divider never stalls.
   function automatic logic [15:0] half_period_of(logic [3:0] code);
      logic [3:0] idx;
      idx = code - 4'd1;
      if (is_pitched(code)) begin
         return HALF_PERIOD[idx];
      end
      return HALF_PERIOD[NOTE_A4 - 4'd1];
   endfunction

endpackage

// File: rtl/square_tone_gen.sv
// Square-wave tone generator.
// A down-counter reloads half_period-1 and toggles the square bit each time it
// reaches zero, so the wave toggles every half_period enabled cycles.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   ena          - freezes counter and square bit when low
//   restart      - reload counter from half_period and clear the square bit
//   half_period  - tone half-period in clock cycles
//   enable_out   - gates the wave output (silence when low)
//   wave         - square-wave output
module square_tone_gen #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             restart,
   input  logic [DIV_W-1:0] half_period,
   input  logic             enable_out,
   output logic             wave
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             sq_q, sq_d;

   always_comb begin
      cnt_d = cnt_q;
      sq_d  = sq_q;
      if (restart) begin
         cnt_d = half_period - DIV_W'(1);
         sq_d  = 1'b0;
      end else if (cnt_q == '0) begin
         cnt_d = half_period - DIV_W'(1);
         sq_d  = ~sq_q;
      end else begin
         cnt_d = cnt_q - DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         sq_q  <= 1'b0;
      end else if (ena) begin
         cnt_q <= cnt_d;
         sq_q  <= sq_d;
      end
   end

   assign wave = sq_q & enable_out;

endmodule

// File: rtl/music_tone_sequencer.sv
// Melody sequencer: steps through the SONG ROM, one step per FRAMES_PER_BEAT
// frame ticks, with a one-frame articulation gap at the end of each beat, and
// drives a square-wave tone for pitched notes.
// Ports:
//   clk, rst_n  - pixel clock, synchronous active-low reset (overrides ena)
//   ena         - low freezes all state and outputs
//   frame_tick  - one-cycle pulse per VGA frame
//   play        - level; high runs the melody, low returns to idle
//   audio_out   - square wave, 0 when silent
//   note_idx    - current melody code (0 when idle)
//   note_valid  - high while a pitched note sounds
//   beat_pulse  - one-cycle pulse on each step advance
// All outputs depend only on registered state.
module music_tone_sequencer
   import music_pkg::*;
#(
   parameter int unsigned SONG_LEN        = 16,
   parameter int unsigned FRAMES_PER_BEAT = 15,
   parameter int unsigned DIV_W           = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       frame_tick,
   input  logic       play,
   output logic       audio_out,
   output logic [3:0] note_idx,
   output logic       note_valid,
   output logic       beat_pulse
);

   localparam int unsigned FC_W = (FRAMES_PER_BEAT > 2) ? $clog2(FRAMES_PER_BEAT) : 1;
   localparam logic [FC_W-1:0] LAST_FRAME = FC_W'(FRAMES_PER_BEAT - 1);
   localparam logic [3:0]      LAST_STEP  = 4'(SONG_LEN - 1);

   state_e          state_q, state_d;
   logic [3:0]      step_q, step_d;
   logic [FC_W-1:0] frame_q, frame_d;
   logic            beat_q, beat_d;
   logic            restart;
   logic [3:0]      cur_code;
   logic [3:0]      next_code;

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      frame_d = frame_q;
      beat_d  = 1'b0;
      restart = 1'b0;
      if (!play) begin
         // Dropping play wins over a coincident tick: no beat, straight to idle.
         state_d = IDLE;
         step_d  = '0;
         frame_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = PLAY;
               step_d  = '0;
               frame_d = '0;
               beat_d  = 1'b1;
               restart = 1'b1;
            end
            PLAY: begin
               if (frame_tick) begin
                  frame_d = frame_q + FC_W'(1);
                  if (frame_d == LAST_FRAME) begin
                     state_d = GAP;
                  end
               end
            end
            GAP: begin
               if (frame_tick) begin
                  frame_d = '0;
                  step_d  = (step_q == LAST_STEP) ? 4'd0 : step_q + 4'd1;
                  state_d = PLAY;
                  beat_d  = 1'b1;
                  restart = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         step_q  <= '0;
         frame_q <= '0;
         beat_q  <= 1'b0;
      end else if (ena) begin
         state_q <= state_d;
         step_q  <= step_d;
         frame_q <= frame_d;
         beat_q  <= beat_d;
      end
   end

   assign cur_code  = SONG[step_q];
   // The tone generator reloads on the same edge the new step is registered,
   // so it must see the upcoming step's period.
   assign next_code = SONG[step_d];

   assign note_idx   = (state_q == IDLE) ? 4'd0 : cur_code;
   assign note_valid = (state_q == PLAY) && is_pitched(cur_code);
   assign beat_pulse = beat_q;

   square_tone_gen #(
      .DIV_W(DIV_W)
   ) u_tone (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .restart    (restart),
      .half_period(DIV_W'(half_period_of(next_code))),
      .enable_out (note_valid),
      .wave       (audio_out)
   );

endmodule
